// File: rtl/sha1_padder_if.sv
// Purpose: bundles the word-in stream and the block-out stream of the SHA-1 padder.
// Ports: in_* = 32-bit message words from the producer; blk_* = 512-bit padded blocks
//        to the compression core; msg_bits = running message length in bits.
interface sha1_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [63:0]  msg_bits;

  // The padder side.
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, msg_bits
  );

  // The producer/consumer side.
  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last, msg_bits
  );
endinterface

// File: rtl/sha1_padder.sv
// Purpose: packs big-endian message words into 512-bit blocks and appends 0x80, zero fill, 64-bit length.
// Latency: full block valid 1 cycle after 16th word; final block 15-i cycles after a marker word at index i.
// Backpressure: in_ready low outside FILL; block held stable in OUT until blk_ready.
// Ports: clk, reset (sync, active low); bus = sha1_padder_if.slave (word stream in, block stream out).
module sha1_padder #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  sha1_padder_if.slave      bus
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    LEN_LO = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        widx_q, widx_d;       // 0..16, 16 means block full
  logic              mark_done_q, mark_done_d;
  logic              in_msg_q, in_msg_d;   // a message has seen in_last and is still padding
  logic [LEN_W-1:0]  len_q, len_d;
  logic              blk_last_q, blk_last_d;
  logic [31:0]       words_q [16];

  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [31:0]       wr_dat;

  logic              in_rdy;
  logic              in_fire;
  logic              blk_fire;
  logic [2:0]        nbytes;
  logic [31:0]       marked_word;
  logic [63:0]       len64;

  // in_ready is gated by reset so it reads 0 during the reset cycle itself.
  assign in_rdy   = (state_q == FILL) && reset;
  assign in_fire  = bus.in_valid && in_rdy;
  assign blk_fire = bus.blk_ready && (state_q == OUT);
  assign len64    = 64'(len_q);

  // Non-last words always carry 4 bytes; out-of-range counts saturate at 4.
  assign nbytes = (!bus.in_last || (bus.in_bytes > 3'd4)) ? 3'd4 : bus.in_bytes;

  // Keep the leading nbytes bytes, drop the 0x80 marker right after them.
  always_comb begin
    marked_word = bus.in_data;
    case (nbytes)
      3'd0:    marked_word = 32'h8000_0000;
      3'd1:    marked_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    marked_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    marked_word = {bus.in_data[31:8], 8'h80};
      default: marked_word = bus.in_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    mark_done_d = mark_done_q;
    in_msg_d    = in_msg_q;
    len_d       = len_q;
    blk_last_d  = blk_last_q;
    wr_en       = 1'b0;
    wr_idx      = widx_q[3:0];
    wr_dat      = 32'h0;

    case (state_q)
      FILL: begin
        if (in_fire) begin
          wr_en  = 1'b1;
          wr_dat = marked_word;
          widx_d = widx_q + 5'd1;
          len_d  = len_q + LEN_W'({nbytes, 3'b000});
          if (bus.in_last) begin
            mark_done_d = (nbytes != 3'd4);
            in_msg_d    = 1'b1;
            state_d     = PAD;
          end else if (widx_q == 5'd15) begin
            blk_last_d = 1'b0;
            state_d    = OUT;
          end
        end
      end

      PAD: begin
        if (widx_q == 5'd16) begin
          // Block filled before the length fits; ship it and continue in a fresh block.
          blk_last_d = 1'b0;
          state_d    = OUT;
        end else if (!mark_done_q) begin
          wr_en       = 1'b1;
          wr_dat      = 32'h8000_0000;
          mark_done_d = 1'b1;
          widx_d      = widx_q + 5'd1;
        end else if (widx_q == 5'd14) begin
          wr_en   = 1'b1;
          wr_dat  = len64[63:32];
          state_d = LEN_LO;
        end else begin
          wr_en  = 1'b1;
          wr_dat = 32'h0;
          widx_d = widx_q + 5'd1;
        end
      end

      LEN_LO: begin
        wr_en      = 1'b1;
        wr_idx     = 4'd15;
        wr_dat     = len64[31:0];
        blk_last_d = 1'b1;
        state_d    = OUT;
      end

      OUT: begin
        if (blk_fire) begin
          widx_d = 5'd0;
          if (blk_last_q) begin
            len_d       = '0;
            mark_done_d = 1'b0;
            in_msg_d    = 1'b0;
            blk_last_d  = 1'b0;
            state_d     = FILL;
          end else if (in_msg_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      widx_q      <= 5'd0;
      mark_done_q <= 1'b0;
      in_msg_q    <= 1'b0;
      len_q       <= '0;
      blk_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        words_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      mark_done_q <= mark_done_d;
      in_msg_q    <= in_msg_d;
      len_q       <= len_d;
      blk_last_q  <= blk_last_d;
      if (wr_en) begin
        words_q[wr_idx] <= wr_dat;
      end
    end
  end

  // Word 0 sits in the most significant slot.
  always_comb begin
    bus.blk_data = '0;
    for (int i = 0; i < 16; i++) begin
      bus.blk_data[511 - 32*i -: 32] = words_q[i];
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.blk_valid = (state_q == OUT);
  assign bus.blk_last  = blk_last_q;
  assign bus.msg_bits  = len64;

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Upstream feeder for the SHA-1 compression core.
- Accepts a byte-granular message as a stream of 32-bit big-endian words and appends the FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length.
- Emits complete 512-bit blocks over a valid/ready handshake and flags the final block of each message.
- One message in flight at a time.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Values below 64 are zero-extended into the 64-bit length field. Legal range 8..64.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset; asserted (0) on a rising clk edge clears all state
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word
- in_data  in  32  message word; first message byte in [31:24]
- in_last  in  1  word is the last of the message
- in_bytes  in  3  valid bytes in the last word, 0..4; ignored (treated as 4) when in_last=0; values >4 treated as 4
- blk_valid  out  1  blk_data holds a complete block
- blk_ready  in  1  consumer accepts block
- blk_data  out  512  block; word 0 at [511:480], word 15 at [31:0]
- blk_last  out  1  block is the final block of the message
- msg_bits  out  64  running bit length of the current message (zero-extended)

Behaviour:
- Reset (reset=0 at a clk edge): state=FILL, widx=0, mark_done=0, length=0, blk_data=0, blk_valid=0, blk_last=0, in_ready=0 during reset and 1 on the first cycle after. Reset mid-message or mid-block discards everything.
- Handshakes occur on a rising edge with valid&ready both high. blk_data and blk_last stay stable while blk_valid=1 and blk_ready=0.
- States:
  - FILL: in_ready=1.
  - PAD, LEN_LO, OUT: in_ready=0.
- FILL, on input handshake:
  - Store the word at widx; increment widx.
  - Add in_bytes*8 to the length counter; wraps mod 2^LEN_W.
  - If in_last=1 and in_bytes<4: bytes beyond in_bytes are replaced by 0x80 followed by zeros (e.g. bytes=1 gives data[31:24],0x80,0x00,0x00). Set mark_done=1.
  - If in_last=1 and in_bytes=4: mark_done=0.
  - If in_last=1: go to PAD.
  - Else, if widx reaches 16: go to OUT with blk_last=0.
- PAD, one action per cycle, in priority order:
  - widx==16: go to OUT, blk_last=0.
  - mark_done=0: word[widx]=0x80000000, mark_done=1, widx++.
  - widx==14: word[14]=len[63:32], go to LEN_LO.
  - Otherwise: word[widx]=0, widx++.
- LEN_LO: word[15]=len[31:0], go to OUT with blk_last=1.
- OUT: blk_valid=1. On block handshake:
  - widx=0 and blk_valid drops.
  - If blk_last=0 and a message is in padding (marker pending or mark_done), go to PAD. Otherwise go to FILL.
  - If blk_last=1: clear the length counter and mark_done, go to FILL.
- A new message's first word can be accepted the cycle after final-block acceptance.
- Latency: a non-final full block gives blk_valid=1 one cycle after the 16th word handshake. For a last word at index i with a marker inside it (i<=13), blk_valid rises 15-i cycles after the handshake edge (index 0 gives 15).
- in_last with in_bytes=0 is legal (empty final word). The marker goes into that word position, and the word does not add length.
- msg_bits reflects the counter after each accepted word and returns to 0 after final-block acceptance.

Test Plan:
- "abc": one word 0x61626300, in_bytes=3, in_last. Response: one block, word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1, blk_valid high 15 cycles after the handshake.
- Empty message: in_bytes=0, in_last, in_data=0xFFFFFFFF. Response: word0=0x80000000, words1..15=0, blk_last=1.
- 14 full words (0x00000001..0x0000000E), last on the 14th, bytes=4. Response: block1 words0..13=data, word14=0x80000000, word15=0, blk_last=0. Block2 words0..14=0, word15=0x000001C0, blk_last=1.
- 16 full words, last on the 16th. Response: block1=data, blk_last=0. Block2 word0=0x80000000, word15=0x00000200, blk_last=1. Repeat with bytes=2 on the 16th word: block1 word15=data[31:16],0x8000; block2 word0=0, word15=0x000001F0.
- Backpressure: hold blk_ready=0 for 10 cycles while blk_valid=1. Response: blk_data/blk_last stable, in_ready=0, no words lost. Next message after acceptance pads correctly, with length restarting from 0.
- Reset: drive reset=0 for one cycle during PAD of "abc". Response: blk_valid=0, msg_bits=0, in_ready=1 the next cycle. Resending "abc" reproduces the block from the first scenario.
